// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and owner encodings plus the latency counter width.
package mem_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   localparam int LAT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with zero flag.
// Holds at zero; load takes priority over decrement.
module arb_lat_counter
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and data (D) requesters.
// Holds the port for MEM_LAT cycles per access and pulses done after it.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
   localparam logic [LAT_W-1:0] S_MAX    = LAT_W'(STARVE_MAX);

   arb_state_t       state;
   arb_state_t       state_n;
   arb_owner_t       owner;
   logic [LAT_W-1:0] d_streak;
   logic [LAT_W-1:0] lat_cnt;
   logic             lat_zero;
   logic             elig_i;
   logic             elig_d;
   logic             grant;
   logic             win_d;
   logic             done_now;

   // A requester in its done cycle is not yet asking again.
   assign elig_i = if_req & ~if_done;
   assign elig_d = d_req & ~d_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant    = 1'b0;
      win_d    = 1'b0;
      done_now = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (elig_i | elig_d) begin
               grant   = 1'b1;
               win_d   = elig_d & ~(elig_i & (d_streak == S_MAX));
               state_n = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (lat_zero) begin
               done_now = 1'b1;
               state_n  = ARB_IDLE;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   arb_lat_counter u_lat (
      .clk      (clk),
      .rst      (rst),
      .load     (grant),
      .dec      (state == ARB_ACCESS),
      .load_val (LAT_LOAD),
      .cnt      (lat_cnt),
      .zero     (lat_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_I;
         d_streak  <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_done <= done_now & (owner == OWN_I);
         d_done  <= done_now & (owner == OWN_D);
         if (grant) begin
            owner     <= win_d ? OWN_D : OWN_I;
            mem_addr  <= win_d ? d_addr : if_addr;
            mem_we    <= win_d & d_we;
            mem_wdata <= win_d ? d_wdata : '0;
            // Streak counts only D wins that kept a live fetch waiting.
            if (win_d && if_req) begin
               if (d_streak < S_MAX) begin
                  d_streak <= d_streak + 1'b1;
               end
            end else begin
               d_streak <= '0;
            end
         end
         if (done_now) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (owner == OWN_I) begin
               if_rdata <= mem_rdata;
            end else begin
               d_rdata <= mem_rdata;
            end
         end
      end
   end

   assign stall_if  = if_req & ~if_done;
   assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Fetch uses addresses with bit7=0, data uses bit7=1, so fetch data never depends on grant order.
module tb_mem_port_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int LAT  = 3;
   localparam int SMAX = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stall_if;
   logic          stall_mem;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   function automatic logic [DW-1:0] init_val(input logic [7:0] a);
      return {a, ~a} ^ 16'h5A3C;
   endfunction

   // Memory: untouched words return a fixed pattern.
   logic [DW-1:0] wmem [256];
   bit            wvld [256];
   assign mem_rdata = wvld[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
   always @(posedge clk) begin
      if (mem_we) begin
         wmem[mem_addr[7:0]] <= mem_wdata;
         wvld[mem_addr[7:0]] <= 1'b1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: busy window arithmetic plus expected-response queues.
   typedef struct {
      int            at;
      logic [DW-1:0] data;
      bit            chk;
   } exp_t;

   exp_t          qi[$];
   exp_t          qd[$];
   logic [DW-1:0] shadow [256];
   bit            shv [256];
   int            busy_until = 0;
   int            acc_s = -1;
   int            acc_e = -1;
   int            done_i_at = -1;
   int            done_d_at = -1;
   int            rst_cyc = -1;
   int            streak = 0;
   logic [AW-1:0] acc_addr = '0;
   logic          acc_we = 1'b0;
   logic [DW-1:0] acc_wd = '0;

   function automatic logic [DW-1:0] exp_read(input logic [7:0] a);
      return shv[a] ? shadow[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         qi.delete();
         qd.delete();
         busy_until = cyc + 1;
         acc_s = -1;
         acc_e = -1;
         done_i_at = -1;
         done_d_at = -1;
         streak = 0;
         rst_cyc = cyc + 1;
      end else if (cyc >= busy_until) begin : arb
         bit   ei, ed, wd;
         exp_t e;
         ei = if_req && (done_i_at != cyc);
         ed = d_req && (done_d_at != cyc);
         if (ei || ed) begin
            wd = ed && !(ei && streak == SMAX);
            acc_s = cyc + 1;
            acc_e = cyc + LAT;
            busy_until = cyc + LAT + 1;
            e.at = cyc + LAT + 1;
            if (wd) begin
               streak = if_req ? ((streak < SMAX) ? streak + 1 : streak) : 0;
               acc_addr = d_addr;
               acc_we = d_we;
               acc_wd = d_wdata;
               done_d_at = e.at;
               if (d_we) begin
                  shadow[d_addr[7:0]] = d_wdata;
                  shv[d_addr[7:0]] = 1'b1;
                  e.data = '0;
                  e.chk = 1'b0;
               end else begin
                  e.data = exp_read(d_addr[7:0]);
                  e.chk = 1'b1;
               end
               qd.push_back(e);
            end else begin
               streak = 0;
               acc_addr = if_addr;
               acc_we = 1'b0;
               acc_wd = '0;
               done_i_at = e.at;
               e.data = init_val(if_addr[7:0]);
               e.chk = 1'b1;
               qi.push_back(e);
            end
         end
      end
      cyc++;
   end

   // Monitor: compares DUT outputs of the current cycle against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin : mon
         bit   xi, xd, in_acc;
         exp_t e;
         xi = (qi.size() > 0) && (qi[0].at == cyc);
         xd = (qd.size() > 0) && (qd[0].at == cyc);
         check("if_done", 32'(if_done), 32'(xi));
         if ((if_done || xi) && qi.size() > 0) begin
            e = qi.pop_front();
            if (if_done && e.chk) check("if_rdata", 32'(if_rdata), 32'(e.data));
         end
         check("d_done", 32'(d_done), 32'(xd));
         if ((d_done || xd) && qd.size() > 0) begin
            e = qd.pop_front();
            if (d_done && e.chk) check("d_rdata", 32'(d_rdata), 32'(e.data));
         end
         in_acc = (cyc >= acc_s) && (cyc <= acc_e);
         check("mem_addr", 32'(mem_addr), in_acc ? 32'(acc_addr) : 32'd0);
         check("mem_we", 32'(mem_we), 32'(in_acc & acc_we));
         if (in_acc && acc_we) check("mem_wdata", 32'(mem_wdata), 32'(acc_wd));
         check("stall_if", 32'(stall_if), 32'(if_req && done_i_at != cyc));
         check("stall_mem", 32'(stall_mem), 32'(d_req && done_d_at != cyc));
         if (cyc == rst_cyc) begin
            check("rst_if_rdata", 32'(if_rdata), 32'd0);
            check("rst_d_rdata", 32'(d_rdata), 32'd0);
         end
      end
   end

   function automatic logic [AW-1:0] new_addr(input bit dside);
      logic [AW-1:0] a;
      a = AW'($urandom);
      if (dside) a[7:0] = 8'h80 | 8'($urandom_range(0, 7));
      else a[7] = 1'b0;
      return a;
   endfunction

   initial begin : drv_i
      forever begin
         @(posedge clk);
         #1;
         if (if_req) begin
            if (if_done) begin
               if ($urandom_range(0, 3) == 0) if_addr = new_addr(1'b0);
               else if_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = new_addr(1'b0);
         end
      end
   end

   initial begin : drv_d
      forever begin
         @(posedge clk);
         #1;
         if (d_req) begin
            if (d_done) begin
               if ($urandom_range(0, 2) == 0) begin
                  d_addr = new_addr(1'b1);
                  d_we = 1'($urandom);
                  d_wdata = DW'($urandom);
               end else begin
                  d_req = 1'b0;
               end
            end
         end else if ($urandom_range(0, 1) == 0) begin
            d_req = 1'b1;
            d_addr = new_addr(1'b1);
            d_we = 1'($urandom);
            d_wdata = DW'($urandom);
         end
      end
   end

   initial begin : main
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(300, 600)) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
      end
      repeat (200) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
